quad_pos_tracker: RTL and testbench

//  Upstream producer for the I2C read-only slave. Decodes two quadrature

---
 rtl/quad_pos_tracker.sv | 186 ++++++++++++++++++
 tb/tb_quad_pos_tracker.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_pos_tracker.sv
// Dual-axis quadrature decoder with saturating 8-bit positions and a coherent
// snapshot (x_pos/y_pos/status) that only moves on snap_req or rst.
module quad_pos_tracker #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  POS_INIT    = 8'd128,
    parameter logic [7:0]  POS_MAX     = 8'd255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       xa,
    input  logic       xb,
    input  logic       ya,
    input  logic       yb,
    input  logic       btn,
    input  logic       snap_req,
    input  logic       clr_req,
    output logic [7:0] x_pos,
    output logic [7:0] y_pos,
    output logic [7:0] status,
    output logic       snap_valid
);

    localparam int unsigned NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_10 = 2'b10;

    localparam logic [1:0] STEP_NONE = 2'b00;
    localparam logic [1:0] STEP_INC  = 2'b01;
    localparam logic [1:0] STEP_DEC  = 2'b10;
    localparam logic [1:0] STEP_ERR  = 2'b11;

    // Synchroniser bits: [4]=btn [3]=ya [2]=yb [1]=xa [0]=xb
    logic [4:0] sync_q [NS];
    logic [4:0] sync_d [NS];

    always_comb begin
        sync_d[0] = {btn, ya, yb, xa, xb};
        for (int unsigned i = 1; i < NS; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NS; i++) begin
            if (rst) sync_q[i] <= '0;
            else     sync_q[i] <= sync_d[i];
        end
    end

    logic [1:0] x_cur, y_cur;
    logic       btn_sync;

    assign x_cur    = sync_q[NS-1][1:0];
    assign y_cur    = sync_q[NS-1][3:2];
    assign btn_sync = sync_q[NS-1][4];

    function automatic logic [1:0] quad_step(input logic [1:0] prv, input logic [1:0] cur);
        logic [1:0] s;
        s = STEP_NONE;
        case (prv)
            PH_00: case (cur) PH_01: s = STEP_INC; PH_10: s = STEP_DEC; PH_11: s = STEP_ERR; default: s = STEP_NONE; endcase
            PH_01: case (cur) PH_11: s = STEP_INC; PH_00: s = STEP_DEC; PH_10: s = STEP_ERR; default: s = STEP_NONE; endcase
            PH_11: case (cur) PH_10: s = STEP_INC; PH_01: s = STEP_DEC; PH_00: s = STEP_ERR; default: s = STEP_NONE; endcase
            default: case (cur) PH_00: s = STEP_INC; PH_11: s = STEP_DEC; PH_01: s = STEP_ERR; default: s = STEP_NONE; endcase
        endcase
        return s;
    endfunction

    logic [1:0] x_prev_q, x_prev_d, y_prev_q, y_prev_d;
    logic [1:0] x_step, y_step;

    // X axis decoder: prev phase always follows the synchronised input
    always_comb begin
        x_prev_d = x_cur;
        x_step   = quad_step(x_prev_q, x_cur);
    end

    // Y axis decoder
    always_comb begin
        y_prev_d = y_cur;
        y_step   = quad_step(y_prev_q, y_cur);
    end

    logic [7:0] x_live_q, x_live_d, y_live_q, y_live_d;
    logic       movx_q, movx_d, movy_q, movy_d;
    logic       satx_q, satx_d, saty_q, saty_d;
    logic       qerr_q, qerr_d;
    logic [1:0] seq_q, seq_d;
    logic [7:0] x_pos_q, x_pos_d, y_pos_q, y_pos_d, status_q, status_d;
    logic       snap_valid_q, snap_valid_d;

    logic       x_blk, y_blk, x_mv, y_mv;
    logic [7:0] x_next, y_next;

    always_comb begin
        x_blk = ((x_step == STEP_INC) && (x_live_q == POS_MAX)) ||
                ((x_step == STEP_DEC) && (x_live_q == 8'd0));
        y_blk = ((y_step == STEP_INC) && (y_live_q == POS_MAX)) ||
                ((y_step == STEP_DEC) && (y_live_q == 8'd0));
        x_mv  = (x_step == STEP_INC) || (x_step == STEP_DEC);
        y_mv  = (y_step == STEP_INC) || (y_step == STEP_DEC);

        x_next = x_live_q;
        if (!x_blk && x_step == STEP_INC) x_next = x_live_q + 8'd1;
        if (!x_blk && x_step == STEP_DEC) x_next = x_live_q - 8'd1;
        y_next = y_live_q;
        if (!y_blk && y_step == STEP_INC) y_next = y_live_q + 8'd1;
        if (!y_blk && y_step == STEP_DEC) y_next = y_live_q - 8'd1;

        x_pos_d      = x_pos_q;
        y_pos_d      = y_pos_q;
        status_d     = status_q;
        seq_d        = seq_q;
        snap_valid_d = 1'b0;

        // Capture uses pre-event state, so a same-cycle event lands in the next window
        if (snap_req) begin
            x_pos_d      = x_live_q;
            y_pos_d      = y_live_q;
            status_d     = {seq_q, qerr_q, saty_q, satx_q, movy_q, movx_q, btn_sync};
            seq_d        = seq_q + 2'd1;
            snap_valid_d = 1'b1;
        end

        if (clr_req) begin
            x_live_d = POS_INIT;
            y_live_d = POS_INIT;
            movx_d   = 1'b0;
            movy_d   = 1'b0;
            satx_d   = 1'b0;
            saty_d   = 1'b0;
            qerr_d   = 1'b0;
        end else begin
            x_live_d = x_next;
            y_live_d = y_next;
            movx_d   = (movx_q & ~snap_req) | x_mv;
            movy_d   = (movy_q & ~snap_req) | y_mv;
            satx_d   = (satx_q & ~snap_req) | x_blk;
            saty_d   = (saty_q & ~snap_req) | y_blk;
            qerr_d   = (qerr_q & ~snap_req) | (x_step == STEP_ERR) | (y_step == STEP_ERR);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_prev_q     <= '0;
            y_prev_q     <= '0;
            x_live_q     <= POS_INIT;
            y_live_q     <= POS_INIT;
            movx_q       <= 1'b0;
            movy_q       <= 1'b0;
            satx_q       <= 1'b0;
            saty_q       <= 1'b0;
            qerr_q       <= 1'b0;
            seq_q        <= '0;
            x_pos_q      <= POS_INIT;
            y_pos_q      <= POS_INIT;
            status_q     <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            x_prev_q     <= x_prev_d;
            y_prev_q     <= y_prev_d;
            x_live_q     <= x_live_d;
            y_live_q     <= y_live_d;
            movx_q       <= movx_d;
            movy_q       <= movy_d;
            satx_q       <= satx_d;
            saty_q       <= saty_d;
            qerr_q       <= qerr_d;
            seq_q        <= seq_d;
            x_pos_q      <= x_pos_d;
            y_pos_q      <= y_pos_d;
            status_q     <= status_d;
            snap_valid_q <= snap_valid_d;
        end
    end

    assign x_pos      = x_pos_q;
    assign y_pos      = y_pos_q;
    assign status     = status_q;
    assign snap_valid = snap_valid_q;

endmodule

// File: tb/tb_quad_pos_tracker.sv
// Directed + randomized bench for quad_pos_tracker against a phase-index
// reference model with a pin-history delay line.
module tb_quad_pos_tracker;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst, xa, xb, ya, yb, btn, snap_req, clr_req;
    logic [7:0] x_pos, y_pos, status;
    logic       snap_valid;

    int errors = 0;
    int checks = 0;

    quad_pos_tracker #(.SYNC_STAGES(S), .POS_INIT(8'd128), .POS_MAX(8'd255)) dut (
        .clk(clk), .rst(rst), .xa(xa), .xb(xb), .ya(ya), .yb(yb), .btn(btn),
        .snap_req(snap_req), .clr_req(clr_req), .x_pos(x_pos), .y_pos(y_pos),
        .status(status), .snap_valid(snap_valid)
    );

    always #5 clk = ~clk;

    // Reference model state
    int         m_lx, m_ly, m_ox, m_oy, m_seq;
    logic [7:0] m_st;
    bit         m_valid, m_movx, m_movy, m_satx, m_saty, m_qerr;
    logic [4:0] hist [0:S];   // pins seen by each delay stage, [0] newest

    int x_ph = 0, y_ph = 0;

    function automatic int phase_of(input logic [1:0] ab);
        case (ab)
            2'b00: return 0;
            2'b01: return 1;
            2'b11: return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] ab_of(input int ph);
        case (ph)
            0: return 2'b00;
            1: return 2'b01;
            2: return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    // +1 / -1 / 0 motion, 2 for an illegal two-phase jump
    function automatic int motion(input logic [1:0] p, input logic [1:0] c);
        int d;
        d = (phase_of(c) - phase_of(p) + 4) % 4;
        if (d == 1) return 1;
        if (d == 3) return -1;
        return d;
    endfunction

    task automatic apply(input int d, inout int pos, inout bit mov, inout bit sat, inout bit err);
        if (d == 2) err = 1;
        else if (d == 1) begin
            mov = 1;
            if (pos == 255) sat = 1; else pos = pos + 1;
        end else if (d == -1) begin
            mov = 1;
            if (pos == 0) sat = 1; else pos = pos - 1;
        end
    endtask

    task automatic model_edge();
        logic [4:0] cur, prv;
        int dx, dy;
        if (rst) begin
            m_lx = 128; m_ly = 128; m_ox = 128; m_oy = 128; m_st = 8'h00;
            m_valid = 0; m_seq = 0;
            m_movx = 0; m_movy = 0; m_satx = 0; m_saty = 0; m_qerr = 0;
            for (int i = 0; i <= S; i++) hist[i] = 5'd0;
        end else begin
            cur = hist[S-1];
            prv = hist[S];
            dx = motion(prv[1:0], cur[1:0]);
            dy = motion(prv[3:2], cur[3:2]);
            m_valid = snap_req;
            if (snap_req) begin
                m_ox = m_lx;
                m_oy = m_ly;
                m_st = {2'(m_seq), m_qerr, m_saty, m_satx, m_movy, m_movx, cur[4]};
                m_seq = (m_seq + 1) % 4;
            end
            if (clr_req) begin
                m_lx = 128; m_ly = 128;
                m_movx = 0; m_movy = 0; m_satx = 0; m_saty = 0; m_qerr = 0;
            end else begin
                if (snap_req) begin
                    m_movx = 0; m_movy = 0; m_satx = 0; m_saty = 0; m_qerr = 0;
                end
                apply(dx, m_lx, m_movx, m_satx, m_qerr);
                apply(dy, m_ly, m_movy, m_saty, m_qerr);
            end
            for (int i = S; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = {btn, ya, yb, xa, xb};
        end
    endtask

    task automatic check_model();
        checks++;
        assert (x_pos === 8'(m_ox)) else begin errors++; $error("FAIL x_pos got=%0d exp=%0d", x_pos, m_ox); end
        checks++;
        assert (y_pos === 8'(m_oy)) else begin errors++; $error("FAIL y_pos got=%0d exp=%0d", y_pos, m_oy); end
        checks++;
        assert (status === m_st) else begin errors++; $error("FAIL status got=%h exp=%h", status, m_st); end
        checks++;
        assert (snap_valid === m_valid) else begin errors++; $error("FAIL snap_valid got=%b exp=%b", snap_valid, m_valid); end
    endtask

    task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin errors++; $error("FAIL %s got=%h exp=%h", tag, got, exp); end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic step_x(input int d);
        x_ph = (x_ph + d + 4) % 4;
        {xa, xb} = ab_of(x_ph);
    endtask

    task automatic step_y(input int d);
        y_ph = (y_ph + d + 4) % 4;
        {ya, yb} = ab_of(y_ph);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic snap();
        snap_req = 1; tick(); snap_req = 0;
    endtask

    task automatic do_reset();
        x_ph = 0; y_ph = 0; {xa, xb} = 2'b00; {ya, yb} = 2'b00;
        btn = 0; snap_req = 0; clr_req = 0; rst = 1;
        tick(); tick();
        rst = 0;
    endtask

    initial begin
        do_reset();
        chk8("reset_x", x_pos, 8'd128);
        chk8("reset_y", y_pos, 8'd128);
        chk8("reset_status", status, 8'h00);
        chk8("reset_valid", {7'd0, snap_valid}, 8'h00);

        // T1: three CW steps on X
        for (int i = 0; i < 3; i++) begin step_x(1); tick(); end
        idle(4);
        snap();
        chk8("t1_x", x_pos, 8'd131);
        chk8("t1_y", y_pos, 8'd128);
        chk8("t1_status", status, 8'h02);
        chk8("t1_valid", {7'd0, snap_valid}, 8'h01);
        tick();
        chk8("t1_valid_drop", {7'd0, snap_valid}, 8'h00);
        snap();
        chk8("t1_seq", status, 8'h40);

        // T2: X saturates high, Y saturates low
        do_reset();
        for (int i = 0; i < 131; i++) begin step_x(1); step_y(-1); tick(); end
        idle(4);
        snap();
        chk8("t2_x", x_pos, 8'd255);
        chk8("t2_y", y_pos, 8'd0);
        chk8("t2_status", status, 8'h1E);
        idle(2);
        snap();
        chk8("t2_flags_clr", {4'd0, status[4:1]}, 8'h00);

        // T3: illegal 00 -> 11 jump on X
        do_reset();
        x_ph = 2; {xa, xb} = 2'b11;
        idle(4);
        snap();
        chk8("t3_x", x_pos, 8'd128);
        chk8("t3_status", status, 8'h20);

        // T4: step reaches the decoder on the snap_req cycle
        do_reset();
        step_x(1);
        idle(S);
        snap();
        chk8("t4_x_first", x_pos, 8'd128);
        chk8("t4_status_first", status, 8'h00);
        idle(2);
        snap();
        chk8("t4_x_next", x_pos, 8'd129);
        chk8("t4_status_next", status, 8'h42);

        // T5: snap_req + clr_req together
        do_reset();
        for (int i = 0; i < 12; i++) begin step_x(1); tick(); end
        idle(4);
        snap_req = 1; clr_req = 1; tick(); snap_req = 0; clr_req = 0;
        chk8("t5_x", x_pos, 8'd140);
        chk8("t5_status", status, 8'h02);
        idle(2);
        snap();
        chk8("t5_x_next", x_pos, 8'd128);
        chk8("t5_status_next", status, 8'h40);

        // T6: button held, reset mid-count
        btn = 1;
        for (int i = 0; i < 3; i++) begin step_x(1); step_y(1); tick(); end
        snap();
        rst = 1; step_x(1); tick(); rst = 0;
        chk8("t6_x", x_pos, 8'd128);
        chk8("t6_y", y_pos, 8'd128);
        chk8("t6_status", status, 8'h00);
        chk8("t6_valid", {7'd0, snap_valid}, 8'h00);
        idle(4);
        chk8("t6_status_hold", status, 8'h00);
        snap();
        chk8("t6_btn", {7'd0, status[0]}, 8'h01);

        // Randomized traffic with biased direction segments
        for (int seg = 0; seg < 12; seg++) begin
            int bx, by;
            bx = ($urandom_range(0, 1) == 1) ? 1 : -1;
            by = ($urandom_range(0, 1) == 1) ? 1 : -1;
            for (int c = 0; c < 200; c++) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 60) step_x(bx); else if (r < 75) step_x(-bx); else if (r < 77) step_x(2);
                r = $urandom_range(0, 99);
                if (r < 60) step_y(by); else if (r < 75) step_y(-by); else if (r < 77) step_y(2);
                if ($urandom_range(0, 19) == 0) btn = ~btn;
                snap_req = ($urandom_range(0, 9) == 0);
                clr_req  = ($urandom_range(0, 39) == 0);
                rst      = ($urandom_range(0, 299) == 0);
                tick();
            end
        end
        snap_req = 0; clr_req = 0; rst = 0;
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
